// File: rtl/amo_pkg.sv
// Shared definitions for the AMO read-modify-write sequencer: command codes,
// FSM state encoding and the RMW command classifier.
package amo_pkg;

  localparam logic [4:0] AMO_SWAP = 5'h04;
  localparam logic [4:0] AMO_LR   = 5'h06;
  localparam logic [4:0] AMO_SC   = 5'h07;
  localparam logic [4:0] AMO_ADD  = 5'h08;
  localparam logic [4:0] AMO_XOR  = 5'h09;
  localparam logic [4:0] AMO_OR   = 5'h0a;
  localparam logic [4:0] AMO_AND  = 5'h0b;
  localparam logic [4:0] AMO_MIN  = 5'h0c;
  localparam logic [4:0] AMO_MAX  = 5'h0d;
  localparam logic [4:0] AMO_MINU = 5'h0e;
  localparam logic [4:0] AMO_MAXU = 5'h0f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_RESP
  } amo_state_e;

  // Swap plus the contiguous 0x8..0xf arithmetic/logic block always write back.
  function automatic logic is_rmw(input logic [4:0] cmd);
    return (cmd == AMO_SWAP) || (cmd[4:3] == 2'b01);
  endfunction

endpackage

// File: rtl/amo_rmw_sequencer_amoalu.sv
// AMOALU: combinational AMO datapath. mask[4] set selects 64-bit arithmetic and
// compare, otherwise the low 32-bit word; unmasked bytes pass the old word through.
module AMOALU
  import amo_pkg::*;
(
  input  logic [7:0]  mask,
  input  logic [4:0]  cmd,
  input  logic [63:0] lhs,
  input  logic [63:0] rhs,
  output logic [63:0] out
);

  logic        w64;
  logic        is_signed;
  logic        lt;
  logic [32:0] sum_lo;
  logic [31:0] sum_hi;
  logic [63:0] result;

  // NOTE: every signal written here gets a value on every path (defaults or a
  // full case with default), otherwise synthesis infers a latch.
  always_comb begin
    w64       = mask[4];
    is_signed = (cmd == AMO_MIN) || (cmd == AMO_MAX);
    sum_lo    = {1'b0, lhs[31:0]} + {1'b0, rhs[31:0]};
    // A 32-bit add must not carry into the upper word.
    sum_hi    = lhs[63:32] + rhs[63:32] + {31'b0, w64 & sum_lo[32]};
    if (w64) lt = is_signed ? ($signed(lhs) < $signed(rhs)) : (lhs < rhs);
    else     lt = is_signed ? ($signed(lhs[31:0]) < $signed(rhs[31:0])) : (lhs[31:0] < rhs[31:0]);

    case (cmd)
      AMO_ADD:            result = {sum_hi, sum_lo[31:0]};
      AMO_XOR:            result = lhs ^ rhs;
      AMO_OR:             result = lhs | rhs;
      AMO_AND:            result = lhs & rhs;
      AMO_MIN, AMO_MINU:  result = lt ? lhs : rhs;
      AMO_MAX, AMO_MAXU:  result = lt ? rhs : lhs;
      default:            result = rhs;
    endcase

    out = lhs;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) out[8*b +: 8] = result[8*b +: 8];
    end
  end

endmodule

// File: rtl/amo_rmw_sequencer.sv
// One-at-a-time atomic read-modify-write sequencer in front of a 64-bit data array.
// Define AMO_LRSC_EN to add load-reserved / store-conditional with one reservation.
module amo_rmw_sequencer
  import amo_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_mask,
  input  logic [63:0]       req_data,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_resp_valid,
  input  logic [63:0]       mem_rd_resp_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [63:0]       mem_wr_data,
  output logic [7:0]        mem_wr_mask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic              busy
);

  amo_state_e        state, state_nxt;
  logic [4:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        mask_q;
  logic [63:0]       data_q;
  logic [63:0]       old_q;
  logic [63:0]       wr_data_q;
  logic [63:0]       alu_out;
  logic              do_write;

  AMOALU u_alu (
    .mask (mask_q),
    .cmd  (cmd_q),
    .lhs  (mem_rd_resp_data),
    .rhs  (data_q),
    .out  (alu_out)
  );

`ifdef AMO_LRSC_EN
  logic              resv_valid;
  logic [ADDR_W-4:0] resv_addr;
  logic              sc_hit;

  assign sc_hit   = resv_valid && (resv_addr == addr_q[ADDR_W-1:3]);
  assign do_write = is_rmw(cmd_q) || ((cmd_q == AMO_SC) && sc_hit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (state == ST_RD_WAIT && mem_rd_resp_valid) begin
      if (cmd_q == AMO_LR) begin
        resv_valid <= 1'b1;
        resv_addr  <= addr_q[ADDR_W-1:3];
      end else if (cmd_q == AMO_SC) begin
        resv_valid <= 1'b0;
      end
    end else if (state == ST_WR_REQ && mem_wr_ready && resv_addr == addr_q[ADDR_W-1:3]) begin
      resv_valid <= 1'b0;
    end
  end
`else
  assign do_write = is_rmw(cmd_q);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; datapath registers are reset too because they drive ports
  // that must read zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      old_q     <= '0;
      wr_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) begin
        cmd_q  <= req_cmd;
        addr_q <= req_addr & ~ADDR_W'(7);
        mask_q <= req_mask;
        data_q <= req_data;
      end
      if (state == ST_RD_WAIT && mem_rd_resp_valid) begin
        old_q     <= mem_rd_resp_data;
        wr_data_q <= alu_out;
`ifdef AMO_LRSC_EN
        // SC reports status instead of the old word and stores the raw operand.
        if (cmd_q == AMO_SC) begin
          old_q     <= {63'b0, !sc_hit};
          wr_data_q <= data_q;
        end
`endif
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    mem_rd_valid = 1'b0;
    mem_wr_valid = 1'b0;
    resp_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        mem_rd_valid = 1'b1;
        if (mem_rd_ready) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rd_resp_valid) state_nxt = do_write ? ST_WR_REQ : ST_RESP;
      end
      ST_WR_REQ: begin
        mem_wr_valid = 1'b1;
        if (mem_wr_ready) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy        = (state != ST_IDLE);
  assign mem_rd_addr = addr_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_wr_mask = mask_q;
  assign resp_data   = old_q;

endmodule

// File: tb/tb_amo_rmw_sequencer.sv
// Directed bench for amo_rmw_sequencer with a zero-wait memory model and
// per-channel stall control; expectations follow AMO_LRSC_EN when defined.
module tb_amo_rmw_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_cmd;
  logic [31:0] req_addr;
  logic [7:0]  req_mask;
  logic [63:0] req_data;
  logic        mem_rd_valid, mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_resp_valid;
  logic [63:0] mem_rd_resp_data;
  logic        mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_mask;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic        busy;

  amo_rmw_sequencer #(.ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_resp_valid(mem_rd_resp_valid), .mem_rd_resp_data(mem_rd_resp_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [64];

  // Per-operation observations, filled by run_op.
  int          first_rd, first_wr, resp_cyc, wr_count;
  int          rd_cycles, wr_cycles, rs_cycles;
  int          stable_err, rdy_err, acc_err;
  logic [63:0] wr_data_obs, resp_obs;
  logic [7:0]  wr_mask_obs;

  // Issues one request at a negedge and runs the memory model until the
  // response handshake; cycle 0 is the request cycle.
  task automatic run_op(input logic [4:0] cmd, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [63:0] data,
                        input int rd_st, input int wr_st, input int rs_st);
    int          rd_held, wr_held, rs_held;
    bit          pend, done;
    logic [31:0] pend_addr, exp_addr;
    logic [63:0] wd_first, rs_first;
    logic [7:0]  wm_first;
    exp_addr = {addr[31:3], 3'b000};
    first_rd = -1; first_wr = -1; resp_cyc = -1; wr_count = 0;
    rd_cycles = 0; wr_cycles = 0; rs_cycles = 0;
    stable_err = 0; rdy_err = 0; acc_err = 0;
    wr_data_obs = '0; resp_obs = '0; wr_mask_obs = '0;
    rd_held = 0; wr_held = 0; rs_held = 0;
    pend = 0; done = 0; pend_addr = '0;
    wd_first = '0; rs_first = '0; wm_first = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      req_valid = (c == 0);
      req_cmd = cmd; req_addr = addr; req_mask = mask; req_data = data;
      mem_rd_resp_valid = pend;
      mem_rd_resp_data  = pend ? mem[pend_addr[8:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
      pend = 0;
      mem_rd_ready = !(mem_rd_valid && rd_held < rd_st);
      if (mem_rd_valid && !mem_rd_ready) rd_held++;
      mem_wr_ready = !(mem_wr_valid && wr_held < wr_st);
      if (mem_wr_valid && !mem_wr_ready) wr_held++;
      resp_ready = !(resp_valid && rs_held < rs_st);
      if (resp_valid && !resp_ready) rs_held++;

      if (c == 0 && !req_ready) acc_err++;
      if (c > 0 && (req_ready || !busy)) rdy_err++;
      if (mem_rd_valid) begin
        rd_cycles++;
        if (first_rd < 0) first_rd = c;
        if (mem_rd_addr !== exp_addr) stable_err++;
        if (mem_rd_ready) begin pend = 1; pend_addr = mem_rd_addr; end
      end
      if (mem_wr_valid) begin
        wr_cycles++;
        if (first_wr < 0) begin first_wr = c; wd_first = mem_wr_data; wm_first = mem_wr_mask; end
        if (mem_wr_addr !== exp_addr || mem_wr_data !== wd_first || mem_wr_mask !== wm_first) stable_err++;
        if (mem_wr_ready) begin
          wr_count++;
          wr_data_obs = mem_wr_data;
          wr_mask_obs = mem_wr_mask;
          for (int b = 0; b < 8; b++)
            if (mem_wr_mask[b]) mem[mem_wr_addr[8:3]][8*b +: 8] = mem_wr_data[8*b +: 8];
        end
      end
      if (resp_valid) begin
        rs_cycles++;
        if (rs_cycles == 1) rs_first = resp_data;
        if (resp_data !== rs_first) stable_err++;
        if (resp_ready) begin resp_cyc = c; resp_obs = resp_data; done = 1; end
      end
      @(negedge clock);
    end
    req_valid = 0; mem_rd_resp_valid = 0;
    mem_rd_ready = 1; mem_wr_ready = 1; resp_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
    checks++; if ({mem_rd_valid, mem_wr_valid, resp_valid, busy} !== 4'b0) begin errors++;
      $display("FAIL reset_valids: got %b exp 0000", {mem_rd_valid, mem_wr_valid, resp_valid, busy}); end
    checks++; if (resp_data !== 64'h0 || mem_wr_data !== 64'h0) begin errors++;
      $display("FAIL reset_data: got resp %h wr %h exp 0", resp_data, mem_wr_data); end
    checks++; if (mem_rd_addr !== 32'h0 || mem_wr_addr !== 32'h0 || mem_wr_mask !== 8'h0) begin errors++;
      $display("FAIL reset_addr_mask: got %h %h %h exp 0", mem_rd_addr, mem_wr_addr, mem_wr_mask); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_add();
    mem[8] = 64'h5;
    run_op(5'h08, 32'h40, 8'hff, 64'h3, 0, 0, 0);
    checks++; if (acc_err !== 0) begin errors++; $display("FAIL add_accept: got %0d exp 0", acc_err); end
    checks++; if (first_rd !== 1) begin errors++; $display("FAIL add_rd_cycle: got %0d exp 1", first_rd); end
    checks++; if (first_wr !== 3) begin errors++; $display("FAIL add_wr_cycle: got %0d exp 3", first_wr); end
    checks++; if (resp_cyc !== 4) begin errors++; $display("FAIL add_resp_cycle: got %0d exp 4", resp_cyc); end
    checks++; if (wr_data_obs !== 64'h8 || wr_mask_obs !== 8'hff) begin errors++;
      $display("FAIL add_write: got %h/%h exp 8/ff", wr_data_obs, wr_mask_obs); end
    checks++; if (resp_obs !== 64'h5) begin errors++; $display("FAIL add_resp: got %h exp 5", resp_obs); end
    checks++; if (wr_count !== 1 || rdy_err !== 0 || stable_err !== 0) begin errors++;
      $display("FAIL add_protocol: got wr %0d rdy %0d stab %0d exp 1 0 0", wr_count, rdy_err, stable_err); end
  endtask

  typedef struct {
    logic [4:0]  cmd;
    logic [7:0]  mask;
    logic [63:0] old;
    logic [63:0] rhs;
    logic [63:0] exp;
  } vec_t;

  task automatic test_alu_ops();
    vec_t vt[12];
    logic [31:0] a;
    vt[0]  = '{5'h04, 8'hff, 64'h1111, 64'hABCD, 64'hABCD};
    vt[1]  = '{5'h09, 8'hff, 64'hFF00, 64'h0FF0, 64'hF0F0};
    vt[2]  = '{5'h0a, 8'hff, 64'hF000, 64'h000F, 64'hF00F};
    vt[3]  = '{5'h0b, 8'hff, 64'hFF0F, 64'h0FFF, 64'h0F0F};
    vt[4]  = '{5'h0c, 8'hff, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE};
    vt[5]  = '{5'h0e, 8'hff, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5, 64'h5};
    vt[6]  = '{5'h0f, 8'hff, 64'h10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vt[7]  = '{5'h08, 8'h0f, 64'h0000_0007_FFFF_FFFF, 64'h1, 64'h0000_0007_0000_0000};
    vt[8]  = '{5'h04, 8'h0f, 64'h1111_1111_2222_2222, 64'hAAAA_AAAA_BBBB_BBBB, 64'h1111_1111_BBBB_BBBB};
    vt[9]  = '{5'h0d, 8'h0f, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0000_0000_0001};
    vt[10] = '{5'h0c, 8'h0f, 64'h0000_0000_8000_0000, 64'h7FFF_FFFF, 64'h0000_0000_8000_0000};
    vt[11] = '{5'h0d, 8'hff, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0000_FFFF_FFFF};
    for (int i = 0; i < 12; i++) begin
      a = 32'h100 + 32'(8 * i) + 32'(i % 8);
      mem[a[8:3]] = vt[i].old;
      run_op(vt[i].cmd, a, vt[i].mask, vt[i].rhs, 0, 0, 0);
      checks++; if (wr_data_obs !== vt[i].exp) begin errors++;
        $display("FAIL alu_wdata[%0d]: got %h exp %h", i, wr_data_obs, vt[i].exp); end
      checks++; if (resp_obs !== vt[i].old) begin errors++;
        $display("FAIL alu_resp[%0d]: got %h exp %h", i, resp_obs, vt[i].old); end
      checks++; if (wr_mask_obs !== vt[i].mask || wr_count !== 1) begin errors++;
        $display("FAIL alu_mask[%0d]: got %h cnt %0d exp %h cnt 1", i, wr_mask_obs, wr_count, vt[i].mask); end
      checks++; if (stable_err !== 0 || resp_cyc !== 4) begin errors++;
        $display("FAIL alu_addr[%0d]: got stab %0d resp_cyc %0d exp 0 4", i, stable_err, resp_cyc); end
    end
  endtask

  task automatic test_backpressure();
    mem[12] = 64'd10;
    run_op(5'h08, 32'h60, 8'hff, 64'd20, 3, 3, 3);
    checks++; if (rd_cycles !== 4 || wr_cycles !== 4 || rs_cycles !== 4) begin errors++;
      $display("FAIL bp_hold: got rd %0d wr %0d rs %0d exp 4 4 4", rd_cycles, wr_cycles, rs_cycles); end
    checks++; if (stable_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d exp 0", stable_err); end
    checks++; if (rdy_err !== 0) begin errors++; $display("FAIL bp_req_ready: got %0d exp 0", rdy_err); end
    checks++; if (wr_count !== 1 || wr_data_obs !== 64'd30) begin errors++;
      $display("FAIL bp_write: got cnt %0d data %h exp 1 1e", wr_count, wr_data_obs); end
    checks++; if (resp_obs !== 64'd10 || resp_cyc !== 13) begin errors++;
      $display("FAIL bp_resp: got %h at %0d exp a at 13", resp_obs, resp_cyc); end
  endtask

  task automatic test_read_only();
    mem[20] = 64'hDEAD;
    run_op(5'h00, 32'hA0, 8'hff, 64'h1234, 0, 0, 0);
    checks++; if (wr_cycles !== 0) begin errors++; $display("FAIL ro_nowrite: got %0d exp 0", wr_cycles); end
    checks++; if (resp_obs !== 64'hDEAD) begin errors++; $display("FAIL ro_resp: got %h exp dead", resp_obs); end
    checks++; if (resp_cyc !== 3) begin errors++; $display("FAIL ro_resp_cycle: got %0d exp 3", resp_cyc); end
    checks++; if (mem[20] !== 64'hDEAD) begin errors++; $display("FAIL ro_mem: got %h exp dead", mem[20]); end
  endtask

  task automatic test_back_to_back();
    mem[48] = 64'h1;
    run_op(5'h08, 32'h180, 8'hff, 64'h1, 0, 0, 0);
    run_op(5'h08, 32'h180, 8'hff, 64'h1, 0, 0, 0);
    checks++; if (acc_err !== 0 || rdy_err !== 0) begin errors++;
      $display("FAIL b2b_accept: got acc %0d rdy %0d exp 0 0", acc_err, rdy_err); end
    checks++; if (resp_obs !== 64'h2 || wr_data_obs !== 64'h3) begin errors++;
      $display("FAIL b2b_data: got resp %h wr %h exp 2 3", resp_obs, wr_data_obs); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit p;
    seen = 0; p = 0;
    mem_wr_ready = 0;
    req_cmd = 5'h08; req_addr = 32'h70; req_mask = 8'hff; req_data = 64'h1;
    for (int c = 0; c < 20; c++) begin
      req_valid = (c == 0);
      mem_rd_resp_valid = p;
      mem_rd_resp_data  = 64'h1;
      p = mem_rd_valid && mem_rd_ready;
      if (mem_wr_valid) begin seen = 1; break; end
      @(negedge clock);
    end
    req_valid = 0; mem_rd_resp_valid = 0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_wr: got %b exp 1", seen); end
    reset = 1'b0;
    #1;
    checks++; if ({mem_rd_valid, mem_wr_valid, resp_valid, busy} !== 4'b0) begin errors++;
      $display("FAIL rst_mid_valids: got %b exp 0000", {mem_rd_valid, mem_wr_valid, resp_valid, busy}); end
    checks++; if (resp_data !== 64'h0 || mem_wr_data !== 64'h0 || mem_wr_mask !== 8'h0) begin errors++;
      $display("FAIL rst_mid_data: got %h %h %h exp 0", resp_data, mem_wr_data, mem_wr_mask); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b exp 1", req_ready); end
    @(negedge clock);
    reset = 1'b1;
    mem_wr_ready = 1;
    @(negedge clock);
    mem_rd_resp_valid = 1; mem_rd_resp_data = 64'h1234;
    @(negedge clock);
    mem_rd_resp_valid = 0;
    checks++; if (resp_data !== 64'h0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_stray: got resp %h busy %b exp 0 0", resp_data, busy); end
    checks++; if ({mem_rd_valid, mem_wr_valid, resp_valid} !== 3'b0) begin errors++;
      $display("FAIL rst_stray_valids: got %b exp 000", {mem_rd_valid, mem_wr_valid, resp_valid}); end
  endtask

  task automatic test_lrsc();
    logic [63:0] exp_resp;
    int          exp_wr;
    mem[16] = 64'h55;
    run_op(5'h06, 32'h80, 8'hff, 64'h0, 0, 0, 0);
    checks++; if (resp_obs !== 64'h55 || wr_cycles !== 0) begin errors++;
      $display("FAIL lr_resp: got %h wr %0d exp 55 0", resp_obs, wr_cycles); end
    run_op(5'h07, 32'h80, 8'hff, 64'h7, 0, 0, 0);
`ifdef AMO_LRSC_EN
    exp_resp = 64'h0; exp_wr = 1;
`else
    exp_resp = 64'h55; exp_wr = 0;
`endif
    checks++; if (resp_obs !== exp_resp || wr_count !== exp_wr) begin errors++;
      $display("FAIL sc1: got resp %h wr %0d exp %h %0d", resp_obs, wr_count, exp_resp, exp_wr); end
`ifdef AMO_LRSC_EN
    checks++; if (wr_data_obs !== 64'h7 || resp_cyc !== 4) begin errors++;
      $display("FAIL sc1_write: got %h at %0d exp 7 at 4", wr_data_obs, resp_cyc); end
    exp_resp = 64'h1;
`endif
    run_op(5'h07, 32'h80, 8'hff, 64'h9, 0, 0, 0);
    checks++; if (resp_obs !== exp_resp || wr_cycles !== 0) begin errors++;
      $display("FAIL sc2: got resp %h wr %0d exp %h 0", resp_obs, wr_cycles, exp_resp); end
    // A plain RMW write to the reserved word kills the reservation.
    run_op(5'h06, 32'h80, 8'hff, 64'h0, 0, 0, 0);
    run_op(5'h08, 32'h80, 8'hff, 64'h1, 0, 0, 0);
    run_op(5'h07, 32'h80, 8'hff, 64'h9, 0, 0, 0);
`ifndef AMO_LRSC_EN
    exp_resp = 64'h56;
`endif
    checks++; if (resp_obs !== exp_resp || wr_cycles !== 0) begin errors++;
      $display("FAIL sc_after_rmw: got resp %h wr %0d exp %h 0", resp_obs, wr_cycles, exp_resp); end
    // Reset drops the reservation.
    run_op(5'h06, 32'h80, 8'hff, 64'h0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op(5'h07, 32'h80, 8'hff, 64'h9, 0, 0, 0);
    checks++; if (resp_obs !== exp_resp || wr_cycles !== 0) begin errors++;
      $display("FAIL sc_after_reset: got resp %h wr %0d exp %h 0", resp_obs, wr_cycles, exp_resp); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b0;
    req_valid = 0; req_cmd = '0; req_addr = '0; req_mask = '0; req_data = '0;
    mem_rd_ready = 1; mem_wr_ready = 1; resp_ready = 1;
    mem_rd_resp_valid = 0; mem_rd_resp_data = '0;
    @(negedge clock);
    test_reset();
    test_add();
    test_alu_ops();
    test_backpressure();
    test_read_only();
    test_back_to_back();
    test_reset_mid();
    test_lrsc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amo_rmw_sequencer.md
# amo_rmw_sequencer

Read-modify-write sequencer that executes one atomic memory operation at a time against a single-ported 64-bit data memory. Accepts an AMO request, reads the old word, computes the new word with the existing `AMOALU`, writes it back, and returns the old word to the requester. Sits between the core's AMO issue port and the data-array arbiter; `AMOALU` is its combinational datapath.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width. Data width is fixed at 64 by `AMOALU`.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid` / `req_ready`  in / out  1 / 1  request handshake.
- `req_cmd`  in  5  AMO command code.
- `req_addr`  in  ADDR_W  byte address; bits [2:0] ignored.
- `req_mask`  in  8  byte enables; bit 4 set selects 64-bit compare.
- `req_data`  in  64  operand (rhs).
- `mem_rd_valid` / `mem_rd_ready`  out / in  1 / 1  read command handshake.
- `mem_rd_addr`  out  ADDR_W  word-aligned read address.
- `mem_rd_resp_valid`  in  1  single-cycle read data strobe, no backpressure.
- `mem_rd_resp_data`  in  64  read data.
- `mem_wr_valid` / `mem_wr_ready`  out / in  1 / 1  write handshake.
- `mem_wr_addr`  out  ADDR_W  word-aligned write address.
- `mem_wr_data`  out  64  merged write data.
- `mem_wr_mask`  out  8  byte enables, equal to captured `req_mask`.
- `resp_valid` / `resp_ready`  out / in  1 / 1  response handshake.
- `resp_data`  out  64  old memory word, or SC status.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Commands: 0x4 swap, 0x8 add, 0x9 xor, 0xa or, 0xb and, 0xc min, 0xd max, 0xe minu, 0xf maxu → read-modify-write. Any other code → read-only: no write phase; `resp_data` = old word.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
  - IDLE: `req_ready`=1; on handshake, capture cmd, addr (bits [2:0] forced to 0), mask, data → RD_REQ.
  - RD_REQ: `mem_rd_valid`=1; on `mem_rd_ready` → RD_WAIT.
  - RD_WAIT: on `mem_rd_resp_valid`, register old word into `resp_data`. Register `AMOALU(mask, cmd, lhs=mem_rd_resp_data, rhs=captured data)` into the write-data register. Then → WR_REQ if RMW, else → RESP.
  - WR_REQ: `mem_wr_valid`=1; on `mem_wr_ready` → RESP.
  - RESP: `resp_valid`=1; on `resp_ready` → IDLE.
- `mem_rd_resp_valid` outside RD_WAIT is ignored. This includes a response that arrives after a mid-operation reset.
- All output valids and data are driven from registers. No combinational path from any input to any valid output.
- Only one operation is in flight at a time.

## Timing
- Reset: state IDLE; `req_ready`=1. `mem_rd_valid`, `mem_wr_valid`, `resp_valid`, `busy`=0. `resp_data`, `mem_wr_data`, and addresses =0. `mem_wr_mask`=0.
- Zero-wait memory, RMW command:
  - Accept in cycle 0.
  - `mem_rd_valid` in cycle 1.
  - Read data in cycle 2.
  - `mem_wr_valid` in cycle 3.
  - `resp_valid` in cycle 4.
- Read-only command: `resp_valid` in cycle 3.
- Next request is accepted no earlier than the cycle after the response handshake.
- Held valids: while a valid is stalled, its associated address, data, and mask stay constant.
- Reset mid-operation aborts immediately to the reset state. A partially issued write is the memory's concern; the sequencer does not retry it.

## Configuration
- `AMO_LRSC_EN` defined: load-reserved and store-conditional are supported with a single reservation {valid, word addr}.
  - 0x6 LR: read-only; sets the reservation to the captured address.
  - 0x7 SC: if the reservation is valid and the address matches, `mem_wr_data` = req_data and `resp_data` = 0. Otherwise there is no write phase and `resp_data` = 1.
  - Every SC clears the reservation.
  - Any RMW write to the reserved address clears the reservation.
  - Reset clears the reservation.
- `AMO_LRSC_EN` undefined: 0x6 and 0x7 are plain read-only commands, and no reservation state exists.

## Structure
- Package `amo_pkg`: command code localparams (`AMO_SWAP`, `AMO_ADD`, `AMO_XOR`, `AMO_OR`, `AMO_AND`, `AMO_MIN`, `AMO_MAX`, `AMO_MINU`, `AMO_MAXU`, `AMO_LR`, `AMO_SC`), the state enum typedef, and the `is_rmw(cmd)` function.
- One sub-module: `AMOALU`, instantiated once on the RD_WAIT capture path.

## Test plan
- Add: mem[0x40]=0x0000_0000_0000_0005, req cmd 0x8, addr 0x40, mask 0xff, data 3, zero-wait memory → write 0x8 with mask 0xff, `resp_data`=5, `resp_valid` in cycle 4.
- Signed 32-bit max: mem=0x0000_0000_FFFF_FFFF, cmd 0xd, mask 0x0f, data 1 → write data low word 0x0000_0001, `resp_data`=0x0000_0000_FFFF_FFFF.
- Backpressure: `mem_rd_ready`, `mem_wr_ready`, and `resp_ready` each held low 3 cycles → respective valid and its address/data stable throughout, `req_ready`=0, single write issued.
- Read-only command 0x0 on mem=0xDEAD → no `mem_wr_valid`, `resp_data`=0xDEAD, `resp_valid` in cycle 3.
- Reset asserted in WR_REQ, then a stray `mem_rd_resp_valid` in IDLE → all valids 0 immediately, stray data ignored, `resp_data`=0.
- With `AMO_LRSC_EN`: LR 0x80, SC 0x80 data 7 → write 7, resp 0. A second SC to 0x80 → no write, resp 1. Without the macro, the same sequence issues no writes.
